fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_ctrl.sv | 100 ++++++++++
 tb/tb_fetch_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: machine width,
// instruction size, default reset vector, FIFO entry layout and PC helpers.
package fetch_ctrl_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VEC = 32'h0000_0000;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer of {pc, instr} pairs with push, pop and flush.
// Flush dominates; a push is accepted when not full or when popping the same cycle.
module fetch_fifo
    import fetch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  fetch_entry_t      i_data,
    output fetch_entry_t      o_head,
    output logic [CNT_W-1:0]  o_count
);

    fetch_entry_t     r_mem [FIFO_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
    assign w_do_push = i_push && !i_flush &&
                       ((r_count < CNT_W'(FIFO_DEPTH)) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Payload storage is not reset; validity is carried entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, combinational imem access, 2-entry
// output buffer and redirect handling. Optional macro FETCH_MISALIGN_CHECK_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    logic [XLEN-1:0] r_pc;
    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;

    logic            w_halted;
    logic            w_misalign;
    logic [XLEN-1:0] w_redirect_target;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic            w_pop;
    logic            w_fetch;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_misalign        = |redirect_pc[1:0];
    assign w_redirect_target = redirect_pc;
    assign misalign_err      = (r_state == ST_HALT);
`else
    assign w_misalign        = 1'b0;
    assign w_redirect_target = pc_align(redirect_pc);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // A misaligned redirect parks the controller until the next reset.
    always_comb begin
        w_state_nxt = r_state;
        w_halted    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (redirect_valid && w_misalign) w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign imem_addr = r_pc;

    // Redirect masks the head for its cycle, which also suppresses any pop.
    assign out_valid = (w_count != '0) && !redirect_valid;
    assign out_pc    = out_valid ? w_head.pc    : '0;
    assign out_instr = out_valid ? w_head.instr : '0;

    assign w_pop   = out_valid && out_ready;
    assign w_fetch = fetch_en && !redirect_valid && !w_halted &&
                     ((w_count < CNT_W'(FIFO_DEPTH)) || w_pop);

    assign w_push_data.pc    = r_pc;
    assign w_push_data.instr = imem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_pc <= RESET_PC;
        else if (redirect_valid) r_pc <= w_redirect_target;
        else if (w_fetch)        r_pc <= pc_next(r_pc);
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then randomized traffic
// checked against a queue-based reference model. Honors FETCH_MISALIGN_CHECK_EN.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic        out_ready;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    bit          m_halt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h4000_0593;
            32'h0000_0004: return 32'h4005_8593;
            32'h0000_0008: return 32'h0145_a803;
            32'h0000_00B4: return 32'h407b_8bb3;
            32'h0000_00C4: return 32'hf45f_f0ef;
            32'h0000_00C8: return 32'h0000_0000;
            default:       return {a[15:0] ^ 16'h5a5a, ~a[31:16]};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0000_0000;
        m_q.delete();
        m_halt = 1'b0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
        bit exp_v;
        bit pop;
        bit fetch;
        fetch_en       = en;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        exp_v = (m_q.size() != 0) && !rv;
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        chk("out_pc",    out_pc,    exp_v ? m_q[0][63:32] : 32'h0);
        chk("out_instr", out_instr, exp_v ? m_q[0][31:0]  : 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_halt});
`endif
        @(posedge clk);
        if (rv) begin
            m_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) m_halt = 1'b1;
            m_pc = rpc;
`else
            m_pc = rpc & 32'hFFFF_FFFC;
`endif
        end else begin
            pop   = exp_v && rdy;
            fetch = en && !m_halt && (m_q.size() < 2 || pop);
            if (pop) void'(m_q.pop_front());
            if (fetch) begin
                m_q.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic peek(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, "_pc"},    out_pc,    pc);
        chk({tag, "_instr"}, out_instr, instr);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc",    out_pc,    32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_misalign",  {31'b0, misalign_err}, 32'h0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] tgt;
        logic        en;
        logic        rdy;
        logic        rv;

        rst            = 1'b1;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("init_out_valid", {31'b0, out_valid}, 32'h0);
        chk("init_out_pc",    out_pc,    32'h0);
        chk("init_out_instr", out_instr, 32'h0);
        chk("init_imem_addr", imem_addr, 32'h0);
        rst = 1'b0;

        // Reset release streaming with ready high.
        step(1, 1, 0, 0); peek("seq0", 1, 32'h0, 32'h4000_0593);
        step(1, 1, 0, 0); peek("seq1", 1, 32'h4, 32'h4005_8593);
        step(1, 1, 0, 0); peek("seq2", 1, 32'h8, 32'h0145_a803);

        // Backpressure right after reset: buffer fills, pc holds at 0x8.
        async_reset();
        repeat (4) step(1, 0, 0, 0);
        chk("hold_addr", imem_addr, 32'h8);
        peek("hold", 1, 32'h0, 32'h4000_0593);
        step(1, 1, 0, 0); peek("resume1", 1, 32'h4, 32'h4005_8593);
        step(1, 1, 0, 0); peek("resume2", 1, 32'h8, 32'h0145_a803);

        // Redirect while full.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h0000_00B4); peek("flush", 0, 32'h0, 32'h0);
        step(1, 1, 0, 0);             peek("rd_b4", 1, 32'hB4, 32'h407b_8bb3);

        step(1, 1, 1, 32'h0000_00C4);
        step(1, 1, 0, 0); peek("rd_c4", 1, 32'hC4, 32'hf45f_f0ef);
        step(1, 1, 0, 0); peek("rd_c8", 1, 32'hC8, 32'h0000_0000);

        // Misaligned redirect.
        step(1, 1, 1, 32'h0000_0006);
        step(1, 1, 0, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        peek("mis0", 0, 32'h0, 32'h0);
        chk("mis_err", {31'b0, misalign_err}, 32'h1);
        repeat (3) step(1, 1, 0, 0);
        peek("mis1", 0, 32'h0, 32'h0);
`else
        peek("mis_clr", 1, 32'h4, 32'h4005_8593);
`endif

        // Mid-stream reset then restart at the reset vector.
        step(1, 1, 0, 0);
        async_reset();
        step(1, 1, 0, 0); peek("restart", 1, 32'h0, 32'h4000_0593);

        // Randomized traffic including wrap-around targets and occasional resets.
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 99) < 85);
            rdy = ($urandom_range(0, 99) < 70);
            rv  = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       tgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
                2:       tgt = $urandom & 32'hFFFF_FFFC;
                default: tgt = ($urandom_range(0, 99) < 20) ?
                               {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))} :
                               {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            step(en, rdy, rv, tgt);
            if ($urandom_range(0, 99) < 2) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
